cnt_probe_capture: RTL and testbench

- Probe-side companion to the in-system source path that drives the dual modulo-counter lab design. Source side: forced reset and counter modules.
- Captures a burst of {cntA, cntB} snapshots, starting on a trigger event such as cntA_EQ_cntB or CoutA.
- Buffers the burst in a small on-chip memory. The host or probe logic reads it out one word per request.
- Sits beside the counter pair in the debug top-level; feeds the probe/readout path.

---
 rtl/cnt_probe_capture_if.sv | 32 +++
 rtl/cnt_probe_capture.sv | 136 +++++++++++++
 tb/tb_cnt_probe_capture.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/cnt_probe_capture_if.sv
// Probe-side capture bus: control/trigger inputs, counter samples and the
// readout handshake shared between the probe host and cnt_probe_capture.
interface cnt_probe_capture_if #(
    parameter int W     = 10,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             arm;
    logic             abort;
    logic             trig;
    logic [W-1:0]     cntA;
    logic [W-1:0]     cntB;
    logic             rd_en;
    logic [2*W-1:0]   rd_data;
    logic             rd_valid;
    logic             armed;
    logic             busy;
    logic             done;
    logic             rd_empty;
    logic [CW-1:0]    wr_cnt;

    modport master (
        output arm, abort, trig, cntA, cntB, rd_en,
        input  rd_data, rd_valid, armed, busy, done, rd_empty, wr_cnt
    );

    modport slave (
        input  arm, abort, trig, cntA, cntB, rd_en,
        output rd_data, rd_valid, armed, busy, done, rd_empty, wr_cnt
    );
endinterface

// File: rtl/cnt_probe_capture.sv
// Trigger-started burst capture of {cntA, cntB} snapshots into a small buffer,
// read back one word per request with one cycle of latency.
module cnt_probe_capture #(
    parameter int W     = 10,
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    cnt_probe_capture_if.slave   bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [CW-1:0] LAST_IDX_C = CW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_C     = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C      = CW'(1);

    logic [1:0]       state_r;
    logic [1:0]       state_nx_s;
    logic [CW-1:0]    wr_cnt_r;
    logic [CW-1:0]    rd_ptr_r;
    logic [2*W-1:0]   mem_r [DEPTH];
    logic [2*W-1:0]   rd_data_r;
    logic             rd_valid_r;
    logic             wr_en_s;
    logic             rd_acc_s;
    logic             clr_s;

    // Next-state decode; abort outranks arm, which outranks trig and rd_en.
    always_comb begin
        state_nx_s = state_r;
        wr_en_s    = 1'b0;
        rd_acc_s   = 1'b0;
        clr_s      = 1'b0;
        if (bus.abort) begin
            state_nx_s = ST_IDLE;
            clr_s      = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.arm) begin
                        state_nx_s = ST_ARMED;
                        clr_s      = 1'b1;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (bus.trig) begin
                        wr_en_s    = 1'b1;
                        state_nx_s = ST_CAPTURE;
                    end else begin
                        state_nx_s = ST_ARMED;
                    end
                end
                ST_CAPTURE: begin
                    wr_en_s = 1'b1;
                    if (wr_cnt_r == LAST_IDX_C) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_CAPTURE;
                    end
                end
                ST_DONE: begin
                    if (bus.arm) begin
                        state_nx_s = ST_ARMED;
                        clr_s      = 1'b1;
                    end else if (bus.rd_en && (rd_ptr_r < FULL_C)) begin
                        rd_acc_s   = 1'b1;
                    end else begin
                        state_nx_s = ST_DONE;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                    clr_s      = 1'b1;
                end
            endcase
        end
    end

    // State and write/read pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            wr_cnt_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            state_r <= state_nx_s;
            if (clr_s) begin
                wr_cnt_r <= '0;
                rd_ptr_r <= '0;
            end else begin
                if (wr_en_s) begin
                    wr_cnt_r <= wr_cnt_r + ONE_C;
                end
                if (rd_acc_s) begin
                    rd_ptr_r <= rd_ptr_r + ONE_C;
                end
            end
        end
    end

    // Snapshot buffer; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_cnt_r[AW-1:0]] <= {bus.cntA, bus.cntB};
        end
    end

    // Registered readout: data holds between accepted reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_acc_s;
            if (rd_acc_s) begin
                rd_data_r <= mem_r[rd_ptr_r[AW-1:0]];
            end
        end
    end

    assign bus.rd_data  = rd_data_r;
    assign bus.rd_valid = rd_valid_r;
    assign bus.armed    = (state_r == ST_ARMED);
    assign bus.busy     = (state_r == ST_CAPTURE);
    assign bus.done     = (state_r == ST_DONE);
    assign bus.rd_empty = (state_r == ST_DONE) && (rd_ptr_r == FULL_C);
    assign bus.wr_cnt   = wr_cnt_r;
endmodule

// File: tb/tb_cnt_probe_capture.sv
// Directed bench for cnt_probe_capture: a burst-level reference model is
// compared every cycle, plus literal expectations from the capture scenarios.
module tb_cnt_probe_capture;
    localparam int W     = 10;
    localparam int DEPTH = 8;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    cnt_probe_capture_if #(.W(W), .DEPTH(DEPTH)) bus ();

    cnt_probe_capture #(.W(W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 waiting for trigger, 2 filling, 3 holding a burst.
    int               m_mode;
    int               m_n;
    int               m_rd;
    logic [2*W-1:0]   m_buf [DEPTH];
    logic [2*W-1:0]   m_rd_data;
    logic             m_rd_valid;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode     <= 0;
            m_n        <= 0;
            m_rd       <= 0;
            m_rd_data  <= '0;
            m_rd_valid <= 1'b0;
        end else begin
            m_rd_valid <= 1'b0;
            if (bus.abort) begin
                m_mode <= 0; m_n <= 0; m_rd <= 0;
            end else if (m_mode == 0) begin
                if (bus.arm) begin m_mode <= 1; m_n <= 0; m_rd <= 0; end
            end else if (m_mode == 1) begin
                if (bus.trig) begin
                    m_buf[0] <= {bus.cntA, bus.cntB};
                    m_n      <= 1;
                    m_mode   <= 2;
                end
            end else if (m_mode == 2) begin
                m_buf[m_n] <= {bus.cntA, bus.cntB};
                m_n        <= m_n + 1;
                if (m_n + 1 == DEPTH) m_mode <= 3;
            end else begin
                if (bus.arm) begin
                    m_mode <= 1; m_n <= 0; m_rd <= 0;
                end else if (bus.rd_en && m_rd < m_n) begin
                    m_rd_data  <= m_buf[m_rd];
                    m_rd_valid <= 1'b1;
                    m_rd       <= m_rd + 1;
                end
            end
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        chk("rd_valid", 32'(bus.rd_valid), 32'(m_rd_valid));
        chk("rd_data",  32'(bus.rd_data),  32'(m_rd_data));
        chk("armed",    32'(bus.armed),    32'(m_mode == 1));
        chk("busy",     32'(bus.busy),     32'(m_mode == 2));
        chk("done",     32'(bus.done),     32'(m_mode == 3));
        chk("rd_empty", 32'(bus.rd_empty), 32'((m_mode == 3) && (m_rd == DEPTH)));
        chk("wr_cnt",   32'(bus.wr_cnt),   32'(m_n));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_arm();
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
    endtask

    int busy_cycles;
    int valid_cnt;
    int wrap_a [8];

    initial begin
        wrap_a = '{7, 8, 9, 0, 1, 2, 3, 4};
        n_tests = 0; n_fail = 0;
        rst = 1'b1;
        bus.arm = 1'b0; bus.abort = 1'b0; bus.trig = 1'b0; bus.rd_en = 1'b0;
        bus.cntA = '0;  bus.cntB = '0;
        tick(); tick();
        chk("reset_rd_data", 32'(bus.rd_data), 32'd0);
        chk("reset_wr_cnt",  32'(bus.wr_cnt),  32'd0);
        rst = 1'b0;

        // Trigger while idle must not capture
        bus.trig = 1'b1; tick(); tick(); bus.trig = 1'b0; tick();
        chk("idle_trig_wr_cnt", 32'(bus.wr_cnt), 32'd0);
        chk("idle_trig_busy",   32'(bus.busy),   32'd0);

        // Basic capture: trigger at 5/3, both counters +1 per cycle
        do_arm();
        chk("armed_after_arm", 32'(bus.armed), 32'd1);
        bus.trig = 1'b1;
        busy_cycles = 0;
        for (int k = 0; k < 10; k++) begin
            bus.cntA = W'(5 + k);
            bus.cntB = W'(3 + k);
            tick();
            bus.trig = 1'b0;
            if (bus.busy) busy_cycles++;
        end
        chk("basic_busy_cycles", 32'(busy_cycles), 32'd7);
        chk("basic_done",   32'(bus.done),   32'd1);
        chk("basic_wr_cnt", 32'(bus.wr_cnt), 32'd8);
        for (int i = 0; i < 8; i++) begin
            bus.rd_en = 1'b1;
            tick();
            chk("basic_rd_valid", 32'(bus.rd_valid), 32'd1);
            chk("basic_rd_data",  32'(bus.rd_data),  {12'd0, W'(5 + i), W'(3 + i)});
        end
        bus.rd_en = 1'b0;
        tick();
        chk("basic_rd_empty", 32'(bus.rd_empty), 32'd1);
        chk("basic_no_valid", 32'(bus.rd_valid), 32'd0);

        // Wrap-around capture, then read past the end
        do_arm();
        bus.trig = 1'b1;
        for (int k = 0; k < 9; k++) begin
            bus.cntA = W'((7 + k) % 10);
            bus.cntB = W'(100 + k);
            tick();
            bus.trig = 1'b0;
        end
        valid_cnt = 0;
        bus.rd_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.rd_valid) begin
                chk("wrap_cntA", 32'(bus.rd_data[2*W-1:W]), 32'(wrap_a[valid_cnt % 8]));
                valid_cnt++;
            end
        end
        bus.rd_en = 1'b0;
        chk("wrap_valid_pulses", 32'(valid_cnt), 32'd8);
        chk("wrap_hold_data", 32'(bus.rd_data), {12'd0, W'(4), W'(107)});
        chk("wrap_rd_empty",  32'(bus.rd_empty), 32'd1);

        // Abort after three samples written
        do_arm();
        bus.trig = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.cntA = W'(20 + k); bus.cntB = W'(40 + k);
            tick();
            bus.trig = 1'b0;
        end
        chk("pre_abort_wr_cnt", 32'(bus.wr_cnt), 32'd3);
        bus.abort = 1'b1; tick(); bus.abort = 1'b0;
        chk("abort_wr_cnt", 32'(bus.wr_cnt), 32'd0);
        chk("abort_busy",   32'(bus.busy),   32'd0);
        bus.rd_en = 1'b1; tick(); bus.rd_en = 1'b0;
        chk("abort_rd_valid", 32'(bus.rd_valid), 32'd0);

        // Full capture, two reads, then arm with rd_en on the same cycle
        do_arm();
        bus.trig = 1'b1;
        for (int k = 0; k < 9; k++) begin
            bus.cntA = W'(300 + k); bus.cntB = W'(600 + k);
            tick();
            bus.trig = 1'b0;
        end
        bus.rd_en = 1'b1; tick(); tick();
        chk("rearm_second_read", 32'(bus.rd_data), {12'd0, W'(301), W'(601)});
        bus.arm = 1'b1; tick(); bus.arm = 1'b0; bus.rd_en = 1'b0;
        chk("rearm_armed",    32'(bus.armed),    32'd1);
        chk("rearm_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rearm_wr_cnt",   32'(bus.wr_cnt),   32'd0);

        // Asynchronous reset between edges mid-capture
        bus.trig = 1'b1; tick(); bus.trig = 1'b0; tick();
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        @(posedge clk); #2;
        rst = 1'b1; #1;
        chk("async_rst_busy",    32'(bus.busy),    32'd0);
        chk("async_rst_wr_cnt",  32'(bus.wr_cnt),  32'd0);
        chk("async_rst_rd_data", 32'(bus.rd_data), 32'd0);
        tick(); rst = 1'b0; tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
